// File: rtl/alu_issue_sequencer.sv
// Issue stage for an 8-bit combinational ALU: command FIFO, registered operand drive,
// opcode-dependent settle wait, result capture. `ALU_ISSUE_SEQ_PERF_EN adds perf counters.
module alu_issue_sequencer #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int ADD_WAIT  = 3,
    parameter int PASS_WAIT = 1,
    parameter int OPC_WAIT  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] alu_i1,
    output logic [WIDTH-1:0] alu_i2,
    output logic [1:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_o1,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data
`ifdef ALU_ISSUE_SEQ_PERF_EN
    ,
    output logic [15:0]      perf_ops,
    output logic [15:0]      perf_stall
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = (ADD_WAIT + OPC_WAIT > 0) ? $clog2(ADD_WAIT + OPC_WAIT + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESULT} state_t;

    logic [1:0]       r_fifo_op [DEPTH];
    logic [WIDTH-1:0] r_fifo_a  [DEPTH];
    logic [WIDTH-1:0] r_fifo_b  [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_alu_i1;
    logic [WIDTH-1:0] r_alu_i2;
    logic [1:0]       r_alu_op;
    logic [WIDTH-1:0] r_res_data;
    logic             r_res_valid;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_head_op;
    logic [CNT_W-1:0] w_base;
    logic [CNT_W-1:0] w_load_cnt;

    assign w_full    = (r_count == (PTR_W + 1)'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push    = cmd_valid & ~w_full;
    assign w_pop     = (r_state == S_IDLE) & ~w_empty;
    assign w_head_op = r_fifo_op[r_rd_ptr];

    // Pass-through opcodes settle fast; add and the undefined opcode take the long path.
    always_comb begin
        w_base = CNT_W'(ADD_WAIT);
        if (w_head_op == 2'b01 || w_head_op == 2'b10) begin
            w_base = CNT_W'(PASS_WAIT);
        end
        w_load_cnt = w_base + ((w_head_op != r_alu_op) ? CNT_W'(OPC_WAIT) : '0);
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_op[r_wr_ptr] <= cmd_op;
            r_fifo_a[r_wr_ptr]  <= cmd_a;
            r_fifo_b[r_wr_ptr]  <= cmd_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ALU drive registers only move on the pop edge, so the ALU inputs are stable
    // for the whole settle window and while the result is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_alu_i1    <= '0;
            r_alu_i2    <= '0;
            r_alu_op    <= 2'b00;
            r_res_data  <= '0;
            r_res_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_alu_i1 <= r_fifo_a[r_rd_ptr];
                        r_alu_i2 <= r_fifo_b[r_rd_ptr];
                        r_alu_op <= w_head_op;
                        r_cnt    <= w_load_cnt;
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_res_data  <= alu_o1;
                        r_res_valid <= 1'b1;
                        r_state     <= S_RESULT;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef ALU_ISSUE_SEQ_PERF_EN
    logic [15:0] r_perf_ops;
    logic [15:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_ops   <= '0;
            r_perf_stall <= '0;
        end else begin
            if (r_res_valid && res_ready && r_perf_ops != 16'hFFFF) begin
                r_perf_ops <= r_perf_ops + 16'd1;
            end
            if (cmd_valid && w_full && r_perf_stall != 16'hFFFF) begin
                r_perf_stall <= r_perf_stall + 16'd1;
            end
        end
    end

    assign perf_ops   = r_perf_ops;
    assign perf_stall = r_perf_stall;
`endif

    assign cmd_ready  = ~w_full;
    assign alu_i1     = r_alu_i1;
    assign alu_i2     = r_alu_i2;
    assign alu_opcode = r_alu_op;
    assign res_valid  = r_res_valid;
    assign res_data   = r_res_data;

endmodule
